// File: rtl/apu_package.sv
// Shared APU package: common widths and request types used by the APU arbitration blocks.
//   WAPUTAG / NDSFLAGS_MULT / NUSFLAGS_MULT : requester tag, rounding and status widths
//   FP_MULT_NB_REQ / FP_MULT_ID_WIDTH       : requesters sharing the FP multiplier, ID width
//   mul_req_t                               : one multiplier request {a, b, rnd, tag}
package apu_package;

  localparam int unsigned WAPUTAG       = 2;
  localparam int unsigned NDSFLAGS_MULT = 3;
  localparam int unsigned NUSFLAGS_MULT = 5;

  localparam int unsigned FP_MULT_WIDTH    = 32;
  localparam int unsigned FP_MULT_NB_REQ   = 4;
  localparam int unsigned FP_MULT_ID_WIDTH = $clog2(FP_MULT_NB_REQ);

  typedef struct packed {
    logic [FP_MULT_WIDTH-1:0] a;
    logic [FP_MULT_WIDTH-1:0] b;
    logic [NDSFLAGS_MULT-1:0] rnd;
    logic [WAPUTAG-1:0]       tag;
  } mul_req_t;

endpackage

// File: rtl/fp_rr_prio.sv
// Combinational cyclic priority select.
//   req   : request vector
//   ptr   : index where the upward cyclic search starts
//   gnt   : one-hot grant (zero when no request)
//   idx   : encoded index of the granted request
//   valid : a request was granted
module fp_rr_prio #(
  parameter int unsigned NB_REQ   = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NB_REQ-1:0]   req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NB_REQ-1:0]   gnt,
  output logic [ID_WIDTH-1:0] idx,
  output logic                valid
);

  logic [ID_WIDTH-1:0] cand;
  logic                found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = ID_WIDTH'((32'(ptr) + i) % NB_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/fp_mult_share_ctrl.sv
// Shares one pipelined FP multiplier among NB_REQ requesters.
//   Req_i/Gnt_o, OpA_i/OpB_i/Rnd_i/Tag_i : per-requester request handshake and operands
//   MulEn_o, MulOp*_o, MulRnd_o, MulTag_o : registered issue to the multiplier
//   MulValid_i, MulRes_i, MulStatus_i, MulTag_i : multiplier return path
//   RValid_o, RRes_o, RStatus_o, RTag_o, Ack_i  : one-entry result buffer per requester
//   Err_o : sticky protocol error (stray, duplicate or out-of-range result)
// One operation in flight per requester keeps each result buffer from overflowing,
// so the multiplier never has to stall.
module fp_mult_share_ctrl
  import apu_package::*;
#(
  parameter int unsigned NB_REQ     = FP_MULT_NB_REQ,
  parameter int unsigned FP_WIDTH   = FP_MULT_WIDTH,
  parameter int unsigned TAG_WIDTH  = WAPUTAG,
  parameter int unsigned RND_WIDTH  = NDSFLAGS_MULT,
  parameter int unsigned STAT_WIDTH = NUSFLAGS_MULT,
  localparam int unsigned ID_WIDTH  = $clog2(NB_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NB_REQ-1:0]               Req_i,
  output logic [NB_REQ-1:0]               Gnt_o,
  input  logic [NB_REQ*FP_WIDTH-1:0]      OpA_i,
  input  logic [NB_REQ*FP_WIDTH-1:0]      OpB_i,
  input  logic [NB_REQ*RND_WIDTH-1:0]     Rnd_i,
  input  logic [NB_REQ*TAG_WIDTH-1:0]     Tag_i,
  output logic                            MulEn_o,
  output logic [FP_WIDTH-1:0]             MulOpA_o,
  output logic [FP_WIDTH-1:0]             MulOpB_o,
  output logic [RND_WIDTH-1:0]            MulRnd_o,
  output logic [ID_WIDTH+TAG_WIDTH-1:0]   MulTag_o,
  input  logic                            MulValid_i,
  input  logic [FP_WIDTH-1:0]             MulRes_i,
  input  logic [STAT_WIDTH-1:0]           MulStatus_i,
  input  logic [ID_WIDTH+TAG_WIDTH-1:0]   MulTag_i,
  output logic [NB_REQ-1:0]               RValid_o,
  output logic [NB_REQ*FP_WIDTH-1:0]      RRes_o,
  output logic [NB_REQ*STAT_WIDTH-1:0]    RStatus_o,
  output logic [NB_REQ*TAG_WIDTH-1:0]     RTag_o,
  input  logic [NB_REQ-1:0]               Ack_i,
  output logic                            Err_o
);

  localparam int unsigned MTAG_WIDTH = ID_WIDTH + TAG_WIDTH;

  logic [NB_REQ-1:0]   busy_q, busy_d, elig, gnt, hit, wr, ack_fire, rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d, gnt_idx, ret_id;
  logic                gnt_valid, ret_err, err_q, mul_en_q;

  logic [FP_WIDTH-1:0]   mul_opa_q, mul_opa_d, mul_opb_q, mul_opb_d;
  logic [RND_WIDTH-1:0]  mul_rnd_q, mul_rnd_d;
  logic [MTAG_WIDTH-1:0] mul_tag_q, mul_tag_d;

  logic [NB_REQ*FP_WIDTH-1:0]   rres_q;
  logic [NB_REQ*STAT_WIDTH-1:0] rstatus_q;
  logic [NB_REQ*TAG_WIDTH-1:0]  rtag_q;

  // A requester with an operation in flight or an unacked result is not eligible.
  assign elig = Req_i & ~busy_q;

  fp_rr_prio #(
    .NB_REQ   (NB_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio (
    .req   (elig),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  assign Gnt_o = gnt;

  // Issue path: idle cycles drive zero operands so the multiplier inputs do not toggle.
  always_comb begin
    mul_opa_d = '0;
    mul_opb_d = '0;
    mul_rnd_d = '0;
    mul_tag_d = '0;
    ptr_d     = ptr_q;
    if (gnt_valid) begin
      mul_opa_d = OpA_i[32'(gnt_idx)*FP_WIDTH +: FP_WIDTH];
      mul_opb_d = OpB_i[32'(gnt_idx)*FP_WIDTH +: FP_WIDTH];
      mul_rnd_d = Rnd_i[32'(gnt_idx)*RND_WIDTH +: RND_WIDTH];
      mul_tag_d = {gnt_idx, Tag_i[32'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH]};
      ptr_d     = (gnt_idx == ID_WIDTH'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Return path decode: hit stays zero for an ID outside 0..NB_REQ-1.
  assign ret_id = MulTag_i[MTAG_WIDTH-1:TAG_WIDTH];

  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      hit[k] = MulValid_i && (ret_id == ID_WIDTH'(k));
    end
  end

  assign ret_err  = MulValid_i && ((hit == '0) || ((hit & ~busy_q) != '0) ||
                                   ((hit & rvalid_q) != '0));
  assign wr       = hit & busy_q & ~rvalid_q;
  assign ack_fire = rvalid_q & Ack_i;

  // A grant needs busy=0 and an ack needs a held result (busy=1), so they never collide.
  assign busy_d   = (busy_q & ~ack_fire) | gnt;
  assign rvalid_d = (rvalid_q & ~ack_fire) | wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      ptr_q     <= '0;
      mul_en_q  <= 1'b0;
      mul_opa_q <= '0;
      mul_opb_q <= '0;
      mul_rnd_q <= '0;
      mul_tag_q <= '0;
      rvalid_q  <= '0;
      rres_q    <= '0;
      rstatus_q <= '0;
      rtag_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      mul_en_q  <= gnt_valid;
      mul_opa_q <= mul_opa_d;
      mul_opb_q <= mul_opb_d;
      mul_rnd_q <= mul_rnd_d;
      mul_tag_q <= mul_tag_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_q | ret_err;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
        if (wr[k]) begin
          rres_q[k*FP_WIDTH +: FP_WIDTH]       <= MulRes_i;
          rstatus_q[k*STAT_WIDTH +: STAT_WIDTH] <= MulStatus_i;
          rtag_q[k*TAG_WIDTH +: TAG_WIDTH]     <= MulTag_i[TAG_WIDTH-1:0];
        end
      end
    end
  end

  assign MulEn_o   = mul_en_q;
  assign MulOpA_o  = mul_opa_q;
  assign MulOpB_o  = mul_opb_q;
  assign MulRnd_o  = mul_rnd_q;
  assign MulTag_o  = mul_tag_q;
  assign RValid_o  = rvalid_q;
  assign RRes_o    = rres_q;
  assign RStatus_o = rstatus_q;
  assign RTag_o    = rtag_q;
  assign Err_o     = err_q;

endmodule

// File: tb/tb_fp_mult_share_ctrl.sv
// Directed bench for fp_mult_share_ctrl with a toy power-of-two multiplier of selectable latency.
module tb_fp_mult_share_ctrl;
  import apu_package::*;

  localparam int NB  = 4;
  localparam int FW  = 32;
  localparam int TW  = WAPUTAG;
  localparam int RW  = NDSFLAGS_MULT;
  localparam int SW  = NUSFLAGS_MULT;
  localparam int IW  = 2;
  localparam int MTW = IW + TW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]    req, gnt, rvalid, ack, ack_man, auto_mask;
  logic [NB*FW-1:0] opa, opb, rres;
  logic [NB*RW-1:0] rnd;
  logic [NB*TW-1:0] tag, rtag;
  logic [NB*SW-1:0] rstatus;
  logic             mul_en, mul_valid, err;
  logic [FW-1:0]    mul_opa, mul_opb, mul_res;
  logic [RW-1:0]    mul_rnd;
  logic [SW-1:0]    mul_status;
  logic [MTW-1:0]   mul_tag_o, mul_tag_i;

  mul_req_t stim [NB];
  int total = 0;
  int bad = 0;

  fp_mult_share_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .Req_i(req), .Gnt_o(gnt),
    .OpA_i(opa), .OpB_i(opb), .Rnd_i(rnd), .Tag_i(tag),
    .MulEn_o(mul_en), .MulOpA_o(mul_opa), .MulOpB_o(mul_opb), .MulRnd_o(mul_rnd),
    .MulTag_o(mul_tag_o), .MulValid_i(mul_valid), .MulRes_i(mul_res),
    .MulStatus_i(mul_status), .MulTag_i(mul_tag_i), .RValid_o(rvalid), .RRes_o(rres),
    .RStatus_o(rstatus), .RTag_o(rtag), .Ack_i(ack), .Err_o(err)
  );

  always_comb begin
    opa = '0; opb = '0; rnd = '0; tag = '0;
    for (int k = 0; k < NB; k++) begin
      opa[k*FW +: FW] = stim[k].a;
      opb[k*FW +: FW] = stim[k].b;
      rnd[k*RW +: RW] = stim[k].rnd;
      tag[k*TW +: TW] = stim[k].tag;
    end
  end

  assign ack = (rvalid & auto_mask) | ack_man;

  // Toy multiplier: exact only for zero-mantissa operands (powers of two).
  function automatic logic [FW-1:0] toy_mul(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [7:0] e;
    e = a[30:23] + b[30:23] - 8'd127;
    return {a[31] ^ b[31], e, 23'd0};
  endfunction

  int             lat;
  logic           model_on, inj_valid, mdl_valid;
  logic [FW-1:0]  inj_res, mdl_res;
  logic [SW-1:0]  inj_status, mdl_status;
  logic [MTW-1:0] inj_tag, mdl_tag;
  logic [3:0]     pv;
  logic [FW-1:0]  pr [4];
  logic [SW-1:0]  ps [4];
  logic [MTW-1:0] pt [4];

  always @(posedge clk) begin
    if (!rst_n) pv <= '0;
    else pv <= {pv[2:0], mul_en};
    pr[0] <= toy_mul(mul_opa, mul_opb);
    ps[0] <= SW'(mul_rnd);
    pt[0] <= mul_tag_o;
    for (int i = 1; i < 4; i++) begin
      pr[i] <= pr[i-1];
      ps[i] <= ps[i-1];
      pt[i] <= pt[i-1];
    end
  end

  always_comb begin
    mdl_valid = 1'b0; mdl_res = '0; mdl_status = '0; mdl_tag = '0;
    if (lat == 0) begin
      mdl_valid = mul_en; mdl_res = toy_mul(mul_opa, mul_opb);
      mdl_status = SW'(mul_rnd); mdl_tag = mul_tag_o;
    end else begin
      mdl_valid = pv[lat-1]; mdl_res = pr[lat-1]; mdl_status = ps[lat-1]; mdl_tag = pt[lat-1];
    end
  end

  assign mul_valid  = model_on ? mdl_valid : inj_valid;
  assign mul_res    = model_on ? mdl_res : inj_res;
  assign mul_status = model_on ? mdl_status : inj_status;
  assign mul_tag_i  = model_on ? mdl_tag : inj_tag;

  task automatic do_reset();
    model_on = 1'b1; lat = 2; auto_mask = '0; ack_man = '0; req = '0;
    inj_valid = 1'b0; inj_res = '0; inj_status = '0; inj_tag = '0;
    for (int k = 0; k < NB; k++)
      stim[k] = '{a: 32'h3F800000, b: 32'h40000000, rnd: RW'(k + 1), tag: TW'(k)};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    total++; if (mul_en !== 1'b0) begin bad++; $display("FAIL reset_mul_en: got %b want 0", mul_en); end
    total++; if ({mul_opa, mul_opb, mul_rnd, mul_tag_o} !== '0) begin
      bad++; $display("FAIL reset_mul_ops: got %h want 0", {mul_opa, mul_opb, mul_rnd, mul_tag_o});
    end
    total++; if (rvalid !== '0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    total++; if ({rres, rstatus, rtag} !== '0) begin
      bad++; $display("FAIL reset_rbuf: got %h want 0", {rres, rstatus, rtag});
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  // All four request continuously, immediate acks, latency 2: grant period of 5 cycles.
  task automatic test_round_robin();
    logic [NB-1:0] eg, er;
    logic ee;
    int k;
    do_reset();
    auto_mask = '1;
    req = '1;
    for (int c = 0; c < 12; c++) begin
      #1;
      eg = (c % 5 == 4) ? '0 : NB'(1 << (c % 5));
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt, eg); end
      ee = (c >= 1) && ((c - 1) % 5 != 4);
      total++; if (mul_en !== ee) begin bad++; $display("FAIL rr_mul_en c=%0d: got %b want %b", c, mul_en, ee); end
      if (ee) begin
        k = (c - 1) % 5;
        total++; if (mul_tag_o !== {IW'(k), TW'(k)}) begin
          bad++; $display("FAIL rr_mul_tag c=%0d: got %h want %h", c, mul_tag_o, {IW'(k), TW'(k)});
        end
        total++; if ({mul_opa, mul_opb} !== {32'h3F800000, 32'h40000000}) begin
          bad++; $display("FAIL rr_mul_ops c=%0d: got %h %h want 3f800000 40000000", c, mul_opa, mul_opb);
        end
      end else begin
        total++; if (mul_opa !== '0) begin bad++; $display("FAIL rr_idle_opa c=%0d: got %h want 0", c, mul_opa); end
      end
      er = (c >= 4 && (c - 4) % 5 != 4) ? NB'(1 << ((c - 4) % 5)) : '0;
      total++; if (rvalid !== er) begin bad++; $display("FAIL rr_rvalid c=%0d: got %b want %b", c, rvalid, er); end
      if (er != '0) begin
        k = (c - 4) % 5;
        total++; if (rres[k*FW +: FW] !== 32'h40000000) begin
          bad++; $display("FAIL rr_rres k=%0d: got %h want 40000000", k, rres[k*FW +: FW]);
        end
        total++; if (rtag[k*TW +: TW] !== TW'(k)) begin
          bad++; $display("FAIL rr_rtag k=%0d: got %h want %h", k, rtag[k*TW +: TW], TW'(k));
        end
        total++; if (rstatus[k*SW +: SW] !== SW'(k + 1)) begin
          bad++; $display("FAIL rr_rstatus k=%0d: got %h want %h", k, rstatus[k*SW +: SW], SW'(k + 1));
        end
      end
      @(negedge clk);
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rr_err: got %b want 0", err); end
    req = '0;
  endtask

  // Requester 2 holds its result; acked in cycle 11, re-granted in cycle 12.
  task automatic test_busy_hold();
    int seen0 = 0, seen1 = 0, seen3 = 0;
    do_reset();
    auto_mask = 4'b1011;
    stim[2].a = 32'h40000000;
    stim[2].b = 32'h40800000;
    req = '1;
    for (int c = 0; c <= 12; c++) begin
      ack_man = (c == 11) ? 4'b0100 : 4'b0000;
      #1;
      if (c >= 3 && c <= 11) begin
        total++; if (gnt[2] !== 1'b0) begin bad++; $display("FAIL hold_no_gnt2 c=%0d: got %b want 0", c, gnt[2]); end
      end
      if (c == 12) begin
        total++; if (gnt[2] !== 1'b1) begin bad++; $display("FAIL hold_regnt2: got %b want 1", gnt[2]); end
        total++; if (rvalid[2] !== 1'b0) begin bad++; $display("FAIL hold_acked: got %b want 0", rvalid[2]); end
      end
      if (c == 5) begin
        total++; if (rvalid[2] !== 1'b0) begin bad++; $display("FAIL hold_early: got %b want 0", rvalid[2]); end
      end
      if (c >= 6 && c <= 11) begin
        total++; if (rvalid[2] !== 1'b1) begin bad++; $display("FAIL hold_rvalid2 c=%0d: got %b want 1", c, rvalid[2]); end
        total++; if (rres[2*FW +: FW] !== 32'h41000000) begin
          bad++; $display("FAIL hold_rres2 c=%0d: got %h want 41000000", c, rres[2*FW +: FW]);
        end
      end
      if (c >= 4 && c <= 11) begin
        seen0 += int'(gnt[0]); seen1 += int'(gnt[1]); seen3 += int'(gnt[3]);
      end
      @(negedge clk);
    end
    total++; if (seen0 == 0 || seen1 == 0 || seen3 == 0) begin
      bad++; $display("FAIL hold_others: got grants %0d %0d %0d want all nonzero", seen0, seen1, seen3);
    end
    req = '0; ack_man = '0;
  endtask

  task automatic test_out_of_order();
    do_reset();
    model_on = 1'b0;
    stim[0].tag = 2'd1;
    stim[3].tag = 2'd2;
    req = 4'b1001; #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ooo_gnt0: got %b want 0001", gnt); end
    @(negedge clk); req = 4'b1000; #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL ooo_gnt3: got %b want 1000", gnt); end
    total++; if (mul_tag_o !== 4'b0001) begin bad++; $display("FAIL ooo_tag0: got %h want 1", mul_tag_o); end
    @(negedge clk); req = '0;
    inj_valid = 1'b1; inj_tag = {2'd3, 2'd2}; inj_res = 32'h41000000; inj_status = 5'h11; #1;
    total++; if (mul_tag_o !== 4'b1110) begin bad++; $display("FAIL ooo_tag3: got %h want e", mul_tag_o); end
    @(negedge clk);
    inj_tag = {2'd0, 2'd1}; inj_res = 32'h40400000; inj_status = 5'h02; #1;
    total++; if (rvalid !== 4'b1000) begin bad++; $display("FAIL ooo_rv3: got %b want 1000", rvalid); end
    total++; if ({rres[3*FW +: FW], rtag[3*TW +: TW], rstatus[3*SW +: SW]} !== {32'h41000000, 2'd2, 5'h11}) begin
      bad++; $display("FAIL ooo_buf3: got %h %h %h want 41000000 2 11",
                      rres[3*FW +: FW], rtag[3*TW +: TW], rstatus[3*SW +: SW]);
    end
    @(negedge clk); inj_valid = 1'b0; #1;
    total++; if (rvalid !== 4'b1001) begin bad++; $display("FAIL ooo_rv30: got %b want 1001", rvalid); end
    total++; if ({rres[0 +: FW], rtag[0 +: TW], rstatus[0 +: SW]} !== {32'h40400000, 2'd1, 5'h02}) begin
      bad++; $display("FAIL ooo_buf0: got %h %h %h want 40400000 1 02", rres[0 +: FW], rtag[0 +: TW], rstatus[0 +: SW]);
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ooo_err: got %b want 0", err); end
    ack_man = 4'b1001;
    @(negedge clk); ack_man = '0; #1;
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL ooo_ack: got %b want 0000", rvalid); end
  endtask

  task automatic test_spurious();
    do_reset();
    model_on = 1'b0;
    inj_valid = 1'b1; inj_tag = {2'd1, 2'd0}; inj_res = 32'hDEADBEEF; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL spur_pre: got %b want 0", err); end
    @(negedge clk); inj_valid = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_err: got %b want 1", err); end
    total++; if (rvalid !== '0) begin bad++; $display("FAIL spur_rvalid: got %b want 0", rvalid); end
    total++; if (rres[1*FW +: FW] !== '0) begin bad++; $display("FAIL spur_rres: got %h want 0", rres[1*FW +: FW]); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL spur_sticky: got %b want 1", err); end
    // Second result for a requester whose buffer is still full.
    do_reset();
    model_on = 1'b0;
    req = 4'b0100; #1;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL dup_gnt: got %b want 0100", gnt); end
    @(negedge clk); req = '0;
    inj_valid = 1'b1; inj_tag = {2'd2, 2'd0}; inj_res = 32'h41000000;
    @(negedge clk); inj_res = 32'h42000000; #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL dup_pre: got %b want 0", err); end
    @(negedge clk); inj_valid = 1'b0; #1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL dup_err: got %b want 1", err); end
    total++; if (rres[2*FW +: FW] !== 32'h41000000) begin
      bad++; $display("FAIL dup_kept: got %h want 41000000", rres[2*FW +: FW]);
    end
    total++; if (rvalid !== 4'b0100) begin bad++; $display("FAIL dup_rvalid: got %b want 0100", rvalid); end
  endtask

  task automatic test_latency0();
    do_reset();
    lat = 0;
    stim[0] = '{a: 32'h40000000, b: 32'h40800000, rnd: 3'd3, tag: 2'd3};
    req = 4'b0001; #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL l0_gnt: got %b want 0001", gnt); end
    @(negedge clk); req = '0; #1;
    total++; if (mul_en !== 1'b1) begin bad++; $display("FAIL l0_en: got %b want 1", mul_en); end
    total++; if (rvalid !== '0) begin bad++; $display("FAIL l0_rv_early: got %b want 0", rvalid); end
    @(negedge clk); #1;
    total++; if (rvalid !== 4'b0001) begin bad++; $display("FAIL l0_rv: got %b want 0001", rvalid); end
    total++; if ({rres[0 +: FW], rtag[0 +: TW], rstatus[0 +: SW]} !== {32'h41000000, 2'd3, 5'd3}) begin
      bad++; $display("FAIL l0_buf: got %h %h %h want 41000000 3 03", rres[0 +: FW], rtag[0 +: TW], rstatus[0 +: SW]);
    end
    total++; if ({err, mul_en} !== 2'b00) begin bad++; $display("FAIL l0_after: got %b want 00", {err, mul_en}); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    lat = 1;
    req = '1;
    repeat (3) @(negedge clk);
    #1;
    total++; if ({rvalid, mul_en} !== 5'b00011) begin
      bad++; $display("FAIL mid_pre: got %b want 00011", {rvalid, mul_en});
    end
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({gnt, rvalid, mul_en, err} !== '0) begin
      bad++; $display("FAIL mid_async_ctl: got %b want 0", {gnt, rvalid, mul_en, err});
    end
    total++; if ({mul_opa, mul_opb, mul_rnd, mul_tag_o, rres, rstatus, rtag} !== '0) begin
      bad++; $display("FAIL mid_async_data: got nonzero want 0");
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010; #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL mid_ptr: got %b want 0010", gnt); end
    @(negedge clk); req = 4'b1000; #1;
    total++; if (mul_tag_o[MTW-1:TW] !== 2'd1) begin
      bad++; $display("FAIL mid_issue_id: got %0d want 1", mul_tag_o[MTW-1:TW]);
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", err); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_busy_hold();
    test_out_of_order();
    test_spurious();
    test_latency0();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
